// File: rtl/my_axi4_lite_reg_bank_pkg.sv
// Shared definitions for the AXI4-Lite register bank: register indices, response codes,
// write/read channel state types and the byte-strobe merge helper.
package my_axi4_lite_reg_bank_pkg;

    localparam logic [1:0] IDX_CTRL    = 2'd0;
    localparam logic [1:0] IDX_SCRATCH = 2'd1;
    localparam logic [1:0] IDX_STATUS  = 2'd2;
    localparam logic [1:0] IDX_ID      = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_HELD  = 1'b1
    } chan_state_t;

    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_PEND = 1'b1
    } rsp_state_t;

    // Write FSM: address and data buffers fill independently, response channel follows.
    typedef struct packed {
        chan_state_t aw;
        chan_state_t w;
        rsp_state_t  b;
    } wr_state_t;

    localparam wr_state_t WR_RESET = '{aw: CH_EMPTY, w: CH_EMPTY, b: RSP_IDLE};

    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle with responder-side and requester-side views.
interface axi4_lite_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slv_port (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport mst_port (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/my_axi4_lite_slv_reg_bank.sv
// AXI4-Lite responder exposing a four-word CTRL/SCRATCH/STATUS/ID register bank.
// Write and read paths are independent state machines; every bus output comes from a flop.
module my_axi4_lite_slv_reg_bank
    import my_axi4_lite_reg_bank_pkg::*;
#(
    parameter int unsigned AXI4_LITE_ADDR_BIT_WIDTH = 4,
    parameter int unsigned AXI4_LITE_DATA_BIT_WIDTH = 32,
    parameter logic [31:0] REG0_INIT                = 32'h0000_0000,
    parameter logic [31:0] REG1_INIT                = 32'h0000_0000,
    parameter logic [31:0] BANK_ID                  = 32'hA5A5_0001
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    axi4_lite_if.slv_port if_s_axi4_lite,
    input  logic [31:0]   i_status,
    output logic [31:0]   o_ctrl,
    output logic          o_ctrl_wr_stb
);

    localparam int unsigned AW = AXI4_LITE_ADDR_BIT_WIDTH;
    localparam int unsigned DW = AXI4_LITE_DATA_BIT_WIDTH;
    localparam int unsigned SW = DW / 8;

    logic          ready_en_q;
    wr_state_t     wr_q;
    wr_state_t     wr_d;
    rsp_state_t    rd_q;
    rsp_state_t    rd_d;

    logic [AW-1:0] aw_addr_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic [DW-1:0] ctrl_q;
    logic [DW-1:0] scratch_q;
    logic [1:0]    bresp_q;
    logic          ctrl_stb_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rd_word;

    logic          aw_hs;
    logic          w_hs;
    logic          b_hs;
    logic          ar_hs;
    logic          r_hs;
    logic          commit;
    logic [1:0]    wr_idx;
    logic [1:0]    rd_idx;
    logic          unused_bits;

    assign aw_hs  = if_s_axi4_lite.awvalid && if_s_axi4_lite.awready;
    assign w_hs   = if_s_axi4_lite.wvalid  && if_s_axi4_lite.wready;
    assign b_hs   = if_s_axi4_lite.bvalid  && if_s_axi4_lite.bready;
    assign ar_hs  = if_s_axi4_lite.arvalid && if_s_axi4_lite.arready;
    assign r_hs   = if_s_axi4_lite.rvalid  && if_s_axi4_lite.rready;
    assign commit = (wr_q.aw == CH_HELD) && (wr_q.w == CH_HELD);
    assign wr_idx = aw_addr_q[3:2];
    assign rd_idx = if_s_axi4_lite.araddr[3:2];

    // Protection bits and byte offsets carry no meaning for a word-wide register bank.
    assign unused_bits = &{1'b0, if_s_axi4_lite.awprot, if_s_axi4_lite.arprot,
                           aw_addr_q[1:0], if_s_axi4_lite.araddr[1:0]};

    // NOTE: flops are written with non-blocking (<=) so every register samples pre-edge
    // values; combinational processes use blocking (=).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_en_q <= 1'b0;
            wr_q       <= WR_RESET;
            rd_q       <= RSP_IDLE;
        end else begin
            ready_en_q <= 1'b1;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    always_comb begin
        // NOTE: the default-first assignment makes every path assign wr_d, so no latch is inferred.
        wr_d = wr_q;
        if (commit) begin
            wr_d.aw = CH_EMPTY;
            wr_d.w  = CH_EMPTY;
            wr_d.b  = RSP_PEND;
        end else begin
            if (aw_hs) begin
                wr_d.aw = CH_HELD;
            end
            if (w_hs) begin
                wr_d.w = CH_HELD;
            end
        end
        if (b_hs) begin
            wr_d.b = RSP_IDLE;
        end
    end

    always_comb begin
        rd_d = rd_q;
        if (ar_hs) begin
            rd_d = RSP_PEND;
        end else if (r_hs) begin
            rd_d = RSP_IDLE;
        end
    end

    // Readies are pure functions of registered state, so they never depend on master inputs.
    always_comb begin
        if_s_axi4_lite.awready = ready_en_q && (wr_q.aw == CH_EMPTY) && (wr_q.b == RSP_IDLE);
        if_s_axi4_lite.wready  = ready_en_q && (wr_q.w  == CH_EMPTY) && (wr_q.b == RSP_IDLE);
        if_s_axi4_lite.bvalid  = (wr_q.b == RSP_PEND);
        if_s_axi4_lite.bresp   = bresp_q;
        if_s_axi4_lite.arready = ready_en_q && (rd_q == RSP_IDLE);
        if_s_axi4_lite.rvalid  = (rd_q == RSP_PEND);
        if_s_axi4_lite.rdata   = rdata_q;
        if_s_axi4_lite.rresp   = RESP_OKAY;
    end

    // NOTE: the AW/W buffers are reset along with the registers; a reset mid-transaction
    // empties both buffers, so a half-received write can never reach a register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            ctrl_q     <= REG0_INIT;
            scratch_q  <= REG1_INIT;
            bresp_q    <= RESP_OKAY;
            ctrl_stb_q <= 1'b0;
        end else begin
            ctrl_stb_q <= 1'b0;
            if (aw_hs) begin
                aw_addr_q <= if_s_axi4_lite.awaddr;
            end
            if (w_hs) begin
                w_data_q <= if_s_axi4_lite.wdata;
                w_strb_q <= if_s_axi4_lite.wstrb;
            end
            if (commit) begin
                bresp_q <= RESP_OKAY;
                case (wr_idx)
                    IDX_CTRL: begin
                        ctrl_q     <= apply_wstrb(ctrl_q, w_data_q, w_strb_q);
                        ctrl_stb_q <= |w_strb_q;
                    end
                    IDX_SCRATCH: begin
                        scratch_q <= apply_wstrb(scratch_q, w_data_q, w_strb_q);
                    end
                    default: begin
                        bresp_q <= RESP_SLVERR;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rd_word = BANK_ID;
        case (rd_idx)
            IDX_CTRL:    rd_word = ctrl_q;
            IDX_SCRATCH: rd_word = scratch_q;
            IDX_STATUS:  rd_word = i_status;
            IDX_ID:      rd_word = BANK_ID;
            default:     rd_word = BANK_ID;
        endcase
    end

    // Capturing on the AR edge returns the pre-commit value when a write lands on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q <= '0;
        end else if (ar_hs) begin
            rdata_q <= rd_word;
        end
    end

    assign o_ctrl        = ctrl_q;
    assign o_ctrl_wr_stb = ctrl_stb_q;

endmodule

// File: tb/tb_my_axi4_lite_slv_reg_bank.sv
// Self-checking bench for my_axi4_lite_slv_reg_bank: vector table, directed corner cases
// and randomized traffic against a register-level reference model.
module tb_my_axi4_lite_slv_reg_bank;

    localparam logic [31:0] R0_INIT = 32'h0000_00C0;
    localparam logic [31:0] R1_INIT = 32'h1111_2222;
    localparam logic [31:0] ID_VAL  = 32'hA5A5_0001;
    localparam int          BOUND   = 20;
    localparam int          NVEC    = 17;

    typedef struct {
        bit          is_wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic [31:0] exp_ctrl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] status;
    logic [31:0] ctrl;
    logic        ctrl_stb;

    int n_checks   = 0;
    int n_errors   = 0;
    int stb_count  = 0;
    int stb_expect = 0;

    logic [31:0] m_reg [0:1];
    vec_t        vecs [NVEC];

    axi4_lite_if #(.ADDR_W(4), .DATA_W(32)) axi ();

    my_axi4_lite_slv_reg_bank #(
        .AXI4_LITE_ADDR_BIT_WIDTH(4),
        .AXI4_LITE_DATA_BIT_WIDTH(32),
        .REG0_INIT(R0_INIT),
        .REG1_INIT(R1_INIT),
        .BANK_ID(ID_VAL)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .if_s_axi4_lite(axi),
        .i_status(status),
        .o_ctrl(ctrl),
        .o_ctrl_wr_stb(ctrl_stb)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ctrl_stb === 1'b1) stb_count++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no handshake within %0d cycles", name, BOUND);
    endtask

    // Reference model: CTRL/SCRATCH words with byte-mask merge, STATUS live, ID constant.
    function automatic logic [31:0] model_read(input logic [1:0] idx);
        case (idx)
            2'd0:    return m_reg[0];
            2'd1:    return m_reg[1];
            2'd2:    return status;
            default: return ID_VAL;
        endcase
    endfunction

    task automatic model_write(input logic [1:0] idx, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        resp = 2'b00;
        if (idx >= 2'd2) begin
            resp = 2'b10;
        end else begin
            m_reg[idx[0]] = (m_reg[idx[0]] & ~mask) | (data & mask);
            if (idx == 2'd0 && strb != 4'h0) stb_expect++;
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, output logic [1:0] resp, output int lat);
        int n;
        axi.wdata  = data;
        axi.wstrb  = strb;
        axi.awaddr = addr;
        axi.bready = 1'b1;
        axi.wvalid = 1'b1;
        if (w_lead > 0) begin
            n = 0;
            while (axi.wready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
            if (n >= BOUND) timeout("w_ready");
            @(negedge clk);
            axi.wvalid = 1'b0;
            repeat (w_lead - 1) @(negedge clk);
        end
        axi.awvalid = 1'b1;
        n = 0;
        while (!(axi.awready === 1'b1 && (axi.wvalid === 1'b0 || axi.wready === 1'b1)) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) timeout("aw_ready");
        @(negedge clk);
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        lat = 1;
        while (axi.bvalid !== 1'b1 && lat < BOUND) begin @(negedge clk); lat++; end
        if (lat >= BOUND) timeout("bvalid");
        resp = axi.bresp;
        @(negedge clk);
        axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        int n;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        axi.rready  = 1'b1;
        n = 0;
        while (axi.arready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        if (n >= BOUND) timeout("ar_ready");
        @(negedge clk);
        axi.arvalid = 1'b0;
        lat = 1;
        while (axi.rvalid !== 1'b1 && lat < BOUND) begin @(negedge clk); lat++; end
        if (lat >= BOUND) timeout("rvalid");
        data = axi.rdata;
        resp = axi.rresp;
        @(negedge clk);
        axi.rready = 1'b0;
    endtask

    function automatic vec_t mk(input bit w, input logic [3:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [1:0] r,
                                input logic [31:0] rd, input logic [31:0] c);
        vec_t v;
        v.is_wr = w; v.addr = a; v.data = d; v.strb = s;
        v.exp_resp = r; v.exp_rdata = rd; v.exp_ctrl = c;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata, old, data;
        logic [1:0]  resp, eresp, idx;
        logic [3:0]  strb, addr;
        int          lat, bv;

        vecs[0]  = mk(0, 4'h0, 32'h0,         4'h0, 2'b00, R0_INIT,       R0_INIT);
        vecs[1]  = mk(0, 4'h4, 32'h0,         4'h0, 2'b00, R1_INIT,       R0_INIT);
        vecs[2]  = mk(1, 4'h0, 32'h1234_5678, 4'hF, 2'b00, 32'h0,         32'h1234_5678);
        vecs[3]  = mk(0, 4'h0, 32'h0,         4'h0, 2'b00, 32'h1234_5678, 32'h1234_5678);
        vecs[4]  = mk(1, 4'h4, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0,         32'h1234_5678);
        vecs[5]  = mk(1, 4'h4, 32'h00AB_0000, 4'h4, 2'b00, 32'h0,         32'h1234_5678);
        vecs[6]  = mk(0, 4'h4, 32'h0,         4'h0, 2'b00, 32'hFFAB_FFFF, 32'h1234_5678);
        vecs[7]  = mk(1, 4'h8, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0,         32'h1234_5678);
        vecs[8]  = mk(0, 4'h8, 32'h0,         4'h0, 2'b00, 32'h0000_CAFE, 32'h1234_5678);
        vecs[9]  = mk(0, 4'hC, 32'h0,         4'h0, 2'b00, ID_VAL,        32'h1234_5678);
        vecs[10] = mk(1, 4'hC, 32'h0,         4'hF, 2'b10, 32'h0,         32'h1234_5678);
        vecs[11] = mk(0, 4'hC, 32'h0,         4'h0, 2'b00, ID_VAL,        32'h1234_5678);
        vecs[12] = mk(1, 4'h5, 32'h0000_00EE, 4'h1, 2'b00, 32'h0,         32'h1234_5678);
        vecs[13] = mk(1, 4'h4, 32'h1234_5678, 4'h0, 2'b00, 32'h0,         32'h1234_5678);
        vecs[14] = mk(0, 4'h7, 32'h0,         4'h0, 2'b00, 32'hFFAB_FFEE, 32'h1234_5678);
        vecs[15] = mk(1, 4'h1, 32'hCAFE_F00D, 4'hA, 2'b00, 32'h0,         32'hCA34_F078);
        vecs[16] = mk(0, 4'h0, 32'h0,         4'h0, 2'b00, 32'hCA34_F078, 32'hCA34_F078);

        rst_n = 1'b0;
        status = 32'h0000_CAFE;
        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        m_reg[0] = R0_INIT;
        m_reg[1] = R1_INIT;

        // Reset state, then readies rise one edge after release
        #12;
        check("rst_ready_valid", 32'({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}), 32'h0);
        check("rst_resp_rdata", 32'({axi.bresp, axi.rresp}) | axi.rdata, 32'h0);
        check("rst_ctrl", ctrl, R0_INIT);
        check("rst_stb", 32'(ctrl_stb), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_no_edge_ready", 32'({axi.awready, axi.wready, axi.arready}), 32'h0);
        @(negedge clk);
        check("rel_one_edge_ready", 32'({axi.awready, axi.wready, axi.arready}), 32'h7);

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, resp, lat);
                model_write(vecs[i].addr[3:2], vecs[i].data, vecs[i].strb, eresp);
                check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("vec%0d_wr_lat", i), lat, 32'd2);
            end else begin
                axi_read(vecs[i].addr, rdata, resp, lat);
                check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
                check($sformatf("vec%0d_rresp", i), 32'(resp), 32'h0);
                check($sformatf("vec%0d_rd_lat", i), lat, 32'd1);
            end
            check($sformatf("vec%0d_ctrl", i), ctrl, vecs[i].exp_ctrl);
        end
        @(negedge clk);
        check("vec_stb_pulses", stb_count, 32'd2);

        // W two cycles ahead of AW; response held under bready=0
        axi.wdata = 32'h0000_5A00; axi.wstrb = 4'b0010; axi.bready = 1'b0;
        check("t3_wready", 32'(axi.wready), 32'h1);
        axi.wvalid = 1'b1;
        @(negedge clk);
        axi.wvalid = 1'b0;
        check("t3_w_held", 32'({axi.wready, axi.awready, axi.bvalid}), 32'h2);
        @(negedge clk);
        axi.awaddr = 4'h4;
        axi.awvalid = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("t3_b_stall", 32'({axi.bvalid, axi.bresp, axi.awready, axi.wready}), 32'h10);
            @(negedge clk);
        end
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        check("t3_b_done", 32'({axi.bvalid, axi.awready, axi.wready}), 32'h3);
        model_write(2'd1, 32'h0000_5A00, 4'b0010, eresp);
        axi_read(4'h4, rdata, resp, lat);
        check("t3_rdata", rdata, 32'hFFAB_5AEE);

        // AR captured on the same edge as a SCRATCH commit; rready low for 4 cycles
        old = model_read(2'd1);
        axi.awaddr = 4'h4; axi.wdata = 32'h1; axi.wstrb = 4'hF;
        check("t5_ready", 32'({axi.awready, axi.wready, axi.arready}), 32'h7);
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        axi.araddr = 4'h4; axi.arvalid = 1'b1; axi.rready = 1'b0;
        @(negedge clk);
        axi.arvalid = 1'b0;
        check("t5_same_edge", 32'({axi.bvalid, axi.rvalid}), 32'h3);
        for (int i = 0; i < 4; i++) begin
            check("t5_rdata_hold", axi.rdata, old);
            check("t5_r_stall", 32'({axi.rvalid, axi.rresp, axi.arready}), 32'h8);
            @(negedge clk);
        end
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
        check("t5_r_done", 32'({axi.rvalid, axi.arready}), 32'h1);
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        model_write(2'd1, 32'h1, 4'hF, eresp);
        axi_read(4'h4, rdata, resp, lat);
        check("t5_new_value", rdata, 32'h0000_0001);

        // Randomized traffic against the model
        for (int k = 0; k < 150; k++) begin
            idx    = 2'($urandom_range(0, 3));
            addr   = {idx, 2'($urandom_range(0, 3))};
            status = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                axi_write(addr, data, strb, int'($urandom_range(0, 2)), resp, lat);
                model_write(idx, data, strb, eresp);
                check("rnd_bresp", 32'(resp), 32'(eresp));
                check("rnd_wr_lat", lat, 32'd2);
            end else begin
                axi_read(addr, rdata, resp, lat);
                check("rnd_rdata", rdata, model_read(idx));
                check("rnd_rresp", 32'(resp), 32'h0);
            end
            check("rnd_ctrl", ctrl, m_reg[0]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
        check("rnd_stb_pulses", stb_count, stb_expect);

        // Reset between AW accept and W arrival
        axi.awaddr = 4'h4;
        check("t6_awready", 32'(axi.awready), 32'h1);
        axi.awvalid = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_async", 32'({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}), 32'h0);
        check("t6_rst_ctrl", ctrl, R0_INIT);
        m_reg[0] = R0_INIT;
        m_reg[1] = R1_INIT;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready_back", 32'({axi.awready, axi.wready, axi.arready}), 32'h7);
        axi.wdata = 32'hBAD0_BAD0; axi.wstrb = 4'hF; axi.wvalid = 1'b1; axi.bready = 1'b1;
        @(negedge clk);
        axi.wvalid = 1'b0;
        bv = 0;
        repeat (6) begin
            if (axi.bvalid === 1'b1) bv++;
            @(negedge clk);
        end
        axi.bready = 1'b0;
        check("t6_no_bvalid", bv, 32'h0);
        axi_read(4'h4, rdata, resp, lat);
        check("t6_scratch_init", rdata, R1_INIT);
        axi_read(4'h0, rdata, resp, lat);
        check("t6_ctrl_init", rdata, R0_INIT);
        check("t6_ctrl_port", ctrl, R0_INIT);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
